// File: rtl/grf_pkg.sv
// Shared types and constants for the GRF commit sink and its trace FIFO.
package grf_pkg;

    localparam int unsigned REG_W = 5;
    localparam int unsigned NREG  = 32;
    localparam int unsigned DW    = 32;

    localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic [DW-1:0]    pc;
        logic [REG_W-1:0] wa;
        logic [DW-1:0]    wd;
    } trace_rec_t;

    localparam int unsigned TRACE_W = $bits(trace_rec_t);

endpackage

// File: rtl/grf_trace_fifo.sv
// Synchronous FIFO with head-register output, valid/ready drain side and
// a sticky overflow flag for records dropped while full.
module grf_trace_fifo #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic [W-1:0] data_i,
    input  logic         ready_i,
    output logic         valid_o,
    output logic [W-1:0] data_o,
    output logic         overflow_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          ovf_q;
    logic          full_c, pop_c, push_c;

    assign valid_o    = (count_q != '0);
    assign full_c     = (count_q == CW'(DEPTH));
    assign pop_c      = valid_o && ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_c     = push_i && (!full_c || pop_c);
    assign overflow_o = ovf_q;
    assign data_o     = valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            if (push_c) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_c)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({push_c, pop_c})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
            if (push_i && full_c && !pop_c) ovf_q <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push_c) mem_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/grf_commit_sink.sv
// W-stage commit sink: 32x32 GRF with zero-cycle W->D bypass, retire counter
// and an optional commit-trace FIFO enabled by defining GRF_TRACE_EN.
module grf_commit_sink
    import grf_pkg::*;
#(
    parameter int unsigned TRACE_DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             W_valid,
    input  logic             W_we,
    input  logic [REG_W-1:0] W_GRF_WA,
    input  logic [DW-1:0]    W_GRF_WD,
    input  logic [DW-1:0]    W_PC,
    input  logic [REG_W-1:0] D_RA1,
    input  logic [REG_W-1:0] D_RA2,
    output logic [DW-1:0]    D_RD1,
    output logic [DW-1:0]    D_RD2,
    output logic [31:0]      retire_cnt,
    output logic             trace_valid,
    input  logic             trace_ready,
    output logic [DW-1:0]    trace_pc,
    output logic [REG_W-1:0] trace_wa,
    output logic [DW-1:0]    trace_wd,
    output logic             trace_overflow
);

    logic [DW-1:0] regs_q [NREG];
    logic [31:0]   retire_cnt_q;
    logic          wr_en_c;

    assign wr_en_c    = W_valid && W_we && (W_GRF_WA != REG_ZERO);
    assign retire_cnt = retire_cnt_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < int'(NREG); i++) regs_q[i] <= '0;
        end else if (wr_en_c) begin
            regs_q[W_GRF_WA] <= W_GRF_WD;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)       retire_cnt_q <= '0;
        else if (W_valid) retire_cnt_q <= retire_cnt_q + 32'd1;
    end

    // $0 reads zero; a same-cycle commit to the read address wins over the array.
    always_comb begin
        D_RD1 = '0;
        D_RD2 = '0;
        if (D_RA1 != REG_ZERO) D_RD1 = (wr_en_c && W_GRF_WA == D_RA1) ? W_GRF_WD : regs_q[D_RA1];
        if (D_RA2 != REG_ZERO) D_RD2 = (wr_en_c && W_GRF_WA == D_RA2) ? W_GRF_WD : regs_q[D_RA2];
    end

`ifdef GRF_TRACE_EN
    trace_rec_t rec_in, rec_out;

    assign rec_in = '{pc: W_PC, wa: W_GRF_WA, wd: W_GRF_WD};

    grf_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .W     (TRACE_W)
    ) u_trace_fifo (
        .clk        (clk),
        .rst_n      (reset),
        .push_i     (wr_en_c),
        .data_i     (rec_in),
        .ready_i    (trace_ready),
        .valid_o    (trace_valid),
        .data_o     (rec_out),
        .overflow_o (trace_overflow)
    );

    assign trace_pc = rec_out.pc;
    assign trace_wa = rec_out.wa;
    assign trace_wd = rec_out.wd;
`else
    logic unused_trace;

    assign unused_trace   = ^{trace_ready, W_PC, 1'(TRACE_DEPTH)};
    assign trace_valid    = 1'b0;
    assign trace_pc       = '0;
    assign trace_wa       = '0;
    assign trace_wd       = '0;
    assign trace_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_grf_commit_sink.sv
// Randomized and directed checks of grf_commit_sink against a queue/array reference model.
module tb_grf_commit_sink;
    import grf_pkg::*;

    localparam int unsigned DEPTH = 8;
`ifdef GRF_TRACE_EN
    localparam bit TEN = 1'b1;
`else
    localparam bit TEN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        W_valid, W_we, trace_ready;
    logic [4:0]  W_GRF_WA, D_RA1, D_RA2;
    logic [31:0] W_GRF_WD, W_PC;
    logic [31:0] D_RD1, D_RD2, retire_cnt, trace_pc, trace_wd;
    logic [4:0]  trace_wa;
    logic        trace_valid, trace_overflow;

    grf_commit_sink #(.TRACE_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .W_valid        (W_valid),
        .W_we           (W_we),
        .W_GRF_WA       (W_GRF_WA),
        .W_GRF_WD       (W_GRF_WD),
        .W_PC           (W_PC),
        .D_RA1          (D_RA1),
        .D_RA2          (D_RA2),
        .D_RD1          (D_RD1),
        .D_RD2          (D_RD2),
        .retire_cnt     (retire_cnt),
        .trace_valid    (trace_valid),
        .trace_ready    (trace_ready),
        .trace_pc       (trace_pc),
        .trace_wa       (trace_wa),
        .trace_wd       (trace_wd),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_cnt;
    logic        m_ovf;
    trace_rec_t  m_q [$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_regs[i] = '0;
        m_cnt = '0;
        m_ovf = 1'b0;
        m_q.delete();
    endtask

    function automatic logic [31:0] exp_rd(input logic [4:0] ra);
        if (ra == 5'd0) return 32'd0;
        if (W_valid && W_we && W_GRF_WA == ra) return W_GRF_WD;
        return m_regs[ra];
    endfunction

    task automatic model_commit();
        logic       push, pop;
        trace_rec_t r;
        push = W_valid && W_we && (W_GRF_WA != 5'd0);
        if (push) m_regs[W_GRF_WA] = W_GRF_WD;
        if (W_valid) m_cnt = m_cnt + 32'd1;
        if (TEN) begin
            pop = (m_q.size() != 0) && trace_ready;
            if (pop) void'(m_q.pop_front());
            if (push) begin
                r.pc = W_PC; r.wa = W_GRF_WA; r.wd = W_GRF_WD;
                if (m_q.size() < DEPTH) m_q.push_back(r);
                else m_ovf = 1'b1;
            end
        end
    endtask

    task automatic check_regs(input string tag);
        chk({tag, "_cnt"}, retire_cnt, m_cnt);
        chk({tag, "_tvalid"}, 32'(trace_valid), 32'(TEN && m_q.size() != 0));
        chk({tag, "_ovf"}, 32'(trace_overflow), 32'(m_ovf));
        if (TEN && m_q.size() != 0) begin
            chk({tag, "_tpc"}, trace_pc, m_q[0].pc);
            chk({tag, "_twa"}, 32'(trace_wa), 32'(m_q[0].wa));
            chk({tag, "_twd"}, trace_wd, m_q[0].wd);
        end else if (!TEN) begin
            chk({tag, "_tpc0"}, trace_pc, 32'd0);
            chk({tag, "_twd0"}, trace_wd, 32'd0);
        end
    endtask

    task automatic drive(input logic v, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [31:0] pc, input logic rdy);
        W_valid = v; W_we = we; W_GRF_WA = wa; W_GRF_WD = wd; W_PC = pc; trace_ready = rdy;
    endtask

    // Called just after a negedge with inputs applied: checks reads, clocks once, checks state.
    task automatic step(input string tag);
        #1;
        chk({tag, "_rd1"}, D_RD1, exp_rd(D_RA1));
        chk({tag, "_rd2"}, D_RD2, exp_rd(D_RA2));
        @(posedge clk);
        model_commit();
        @(negedge clk);
        check_regs(tag);
    endtask

    initial begin
        int n;
        reset = 1'b0;
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        D_RA1 = 5'd3; D_RA2 = 5'd9;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        chk("reset_rd1", D_RD1, 32'd0);
        reset = 1'b1;

        // bypass then array read
        drive(1'b1, 1'b1, 5'd8, 32'h1234, 32'h1000, 1'b0);
        D_RA1 = 5'd8; D_RA2 = 5'd8;
        #1 chk("t1_bypass", D_RD1, 32'h1234);
        step("t1a");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        step("t1b");
        chk("t1_array", D_RD1, 32'h1234);

        // write to $0
        drive(1'b1, 1'b1, 5'd0, 32'hFFFF_FFFF, 32'h1008, 1'b0);
        D_RA1 = 5'd0; D_RA2 = 5'd0;
        step("t2");
        chk("t2_cnt", retire_cnt, 32'd2);

        // W_we without W_valid
        drive(1'b0, 1'b1, 5'd5, 32'd7, 32'h100C, 1'b0);
        D_RA1 = 5'd5; D_RA2 = 5'd8;
        step("t3a");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        step("t3b");
        chk("t3_reg5", D_RD1, 32'd0);

`ifdef GRF_TRACE_EN
        for (int i = 0; i < int'(DEPTH) + 2; i++) begin
            drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
            step("t4_pre");
        end
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, 1'b1, 5'(i + 1), $urandom, 32'h3000 + 32'(4 * i), 1'b0);
            step("t4_fill");
        end
        chk("t4_overflow", 32'(trace_overflow), 32'd1);
        for (int k = 0; k < 8; k++) begin
            chk("t4_order", trace_pc, 32'h3000 + 32'(4 * k));
            drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
            step("t4_drain");
        end
        chk("t4_empty", 32'(trace_valid), 32'd0);

        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, 5'(i + 10), $urandom, 32'h4000 + 32'(4 * i), 1'b0);
            step("t5_fill");
        end
        drive(1'b1, 1'b1, 5'd9, 32'hABCD, 32'h4100, 1'b1);
        step("t5_pushpop");
        chk("t5_head", trace_pc, 32'h4004);
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (trace_valid) n++;
            drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
            step("t5_drain");
        end
        chk("t5_count", 32'(n), 32'd8);
`endif

        for (int i = 0; i < 300; i++) begin
            drive($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom), $urandom, $urandom,
                  1'($urandom));
            D_RA1 = ($urandom_range(0, 3) == 0) ? W_GRF_WA : 5'($urandom);
            D_RA2 = ($urandom_range(0, 3) == 0) ? W_GRF_WA : 5'($urandom);
            step("rand");
        end

        // counter wrap from a preloaded value
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b1);
        force dut.retire_cnt_q = 32'hFFFF_FFFE;
        #1 release dut.retire_cnt_q;
        m_cnt = 32'hFFFF_FFFE;
        chk("wrap_preload", retire_cnt, 32'hFFFF_FFFE);
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'($urandom), 5'($urandom), $urandom, $urandom, 1'b0);
            step("wrap");
        end
        chk("wrap_value", retire_cnt, 32'd1);

        // async reset between clock edges
        drive(1'b1, 1'b1, 5'd3, 32'hCAFE_F00D, 32'h5000, 1'b0);
        D_RA1 = 5'd3; D_RA2 = 5'd8;
        step("prerst");
        drive(1'b0, 1'b0, 5'd0, 32'd0, 32'd0, 1'b0);
        #2 reset = 1'b0;
        #1;
        model_reset();
        chk("arst_cnt", retire_cnt, 32'd0);
        chk("arst_tvalid", 32'(trace_valid), 32'd0);
        chk("arst_ovf", 32'(trace_overflow), 32'd0);
        chk("arst_tpc", trace_pc, 32'd0);
        chk("arst_twa", 32'(trace_wa), 32'd0);
        chk("arst_twd", trace_wd, 32'd0);
        chk("arst_rd1", D_RD1, 32'd0);
        chk("arst_rd2", D_RD2, 32'd0);
        @(negedge clk);
        reset = 1'b1;
        step("postrst");

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
